trig_bcd_unit: RTL and testbench
================================

TRIG_BCD_UNIT -- requirements
Module: trig_bcd_unit

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD output digits, range 2..8.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fraction width of the internal magnitude, range 12..24.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port angle, input, 9 bits: angle in whole degrees; 0..360 valid.
REQ-006 SHALL have port mode, input, 1 bit: 0 = sine, 1 = cosine.
REQ-007 SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high from the accepting edge until done.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the result registers update.
REQ-010 SHALL have port digits, output, DIGITS*4 bits: BCD result; most significant nibble is the integer digit, the remaining nibbles are fraction digits.
REQ-011 SHALL have port sign, output, 1 bit: 1 = negative result.
REQ-012 SHALL have port err, output, 1 bit: 1 = the last request had angle > 360.

Function
REQ-013 SHALL implement FSM states IDLE, REDUCE, LOOKUP, CONVERT, DONE.
REQ-014 IDLE: SHALL capture angle and mode and move to REDUCE when start=1; otherwise SHALL stay in IDLE.
REQ-015 SHALL ignore start while busy, with no queuing and no effect on the current operation.
REQ-016 REDUCE: SHALL fold the angle to a reduced angle r in 0..90 and a negative flag.
  - Cosine SHALL use angle+90, taken modulo 360.
  - Quadrant rules: sin(a) = sin(180-a) for 90<a<=180; -sin(a-180) for 180<a<=270; -sin(360-a) for 270<a<=360.
REQ-017 LOOKUP: SHALL register the magnitude of sin(r) in unsigned Q1.FRAC_BITS format, rounded to nearest; sin(90) SHALL equal exactly 1.0.
REQ-018 CONVERT: SHALL take exactly DIGITS cycles.
  - Cycle 0 SHALL emit the integer bit as the most significant digit.
  - Each later cycle SHALL compute frac = frac*10 and emit floor(frac) as the next digit, keeping the fractional remainder (truncation, no rounding).
REQ-019 DONE: SHALL load digits, sign and err together, pulse done for one cycle, and return to IDLE.
REQ-020 Latency from the start-accepting edge to done high SHALL be DIGITS+3 cycles; start SHALL be accepted again in the cycle after done.
REQ-021 digits, sign and err SHALL hold their values between done pulses.
REQ-022 A zero result SHALL force sign=0 (no negative zero).
REQ-023 When angle > 360: REDUCE SHALL skip to DONE with digits all zero, sign=0, err=1, and the same done pulse; latency is 2 cycles.
REQ-024 angle 0 and angle 360 SHALL give identical results.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, digits=0, sign=0, err=0, and clear all internal registers.
REQ-026 Reset during any non-IDLE state SHALL abort the operation with no done pulse; the first start after reset release SHALL be serviced normally.

Structure
REQ-027 Shared package trig_pkg SHALL hold: FSM state encodings, default DIGITS and FRAC_BITS, and the ROM depth constant (91).
REQ-028 SHALL contain one sub-module, sin_quarter_rom, holding sin(0..90 degrees) in Q1.FRAC_BITS with a registered read of 1-cycle latency.
REQ-029 The BCD conversion SHALL use a shift-add implementation of ×10 ((x<<3)+(x<<1)); no generic multiplier is allowed.

Verification
REQ-030 With DIGITS=4: angle=0, mode=0 -> digits 0,0,0,0, sign=0; angle=90, mode=0 -> digits 1,0,0,0, sign=0.
REQ-031 angle=45, mode=0 -> digits 0,7,0,7, sign=0; angle=60, mode=1 -> digits 0,5,0,0, sign=0.
REQ-032 angle=100, mode=0 -> digits 0,9,8,4, sign=0; angle=260, mode=0 -> digits 0,9,8,4, sign=1; angle=180 -> sign=0.
REQ-033 angle=400 -> err=1, digits all zero, done 2 cycles after start; a following angle=360 request -> err=0, digits 0,0,0,0.
REQ-034 start held high for 20 cycles -> exactly one done every DIGITS+4 cycles, with busy high between; rst_n pulsed low in CONVERT -> no done, all outputs 0.
REQ-035 Repeat REQ-030..REQ-032 with DIGITS=6 -> six digits, done at DIGITS+3 cycles; angle=45 -> digits 0,7,0,7,1,0.

Source files
------------

// File: rtl/trig_pkg.sv
// ============================================================================
//  Module      : trig_pkg
//  Description : Shared types and constants for the sine/cosine BCD unit:
//                FSM state encoding, default geometry, ROM depth and the
//                elaboration-time sine table generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trig_pkg;

    localparam int c_default_digits    = 4;
    localparam int c_default_frac_bits = 16;
    localparam int c_rom_depth         = 91;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REDUCE  = 3'd1,
        ST_LOOKUP  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Constant-only helper: sin(deg) in Q1.frac_bits, rounded to nearest.
    // Evaluated with a Q30 Taylor series; 90 degrees is pinned to exactly 1.0.
    function automatic longint sin_q(input int deg, input int frac_bits);
        longint x;
        longint x2;
        longint term;
        longint sum;
        if (deg >= 90) begin
            sin_q = longint'(1) << frac_bits;
        end else begin
            // pi * 2^30 = 3373259426
            x    = (longint'(deg) * 64'sd3373259426) / 180;
            x2   = (x * x) >>> 30;
            term = x;
            sum  = x;
            for (int k = 1; k <= 8; k++) begin
                term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
                sum  = sum + term;
            end
            sin_q = (sum + (longint'(1) << (29 - frac_bits))) >>> (30 - frac_bits);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/sin_quarter_rom.sv
// ============================================================================
//  Module      : sin_quarter_rom
//  Description : Quarter-wave sine table, sin(0..90 deg) in Q1.FRAC_BITS,
//                with a registered read (one cycle of latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sin_quarter_rom
    import trig_pkg::*;
#(
    parameter int FRAC_BITS = c_default_frac_bits
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           i_addr,
    output logic [FRAC_BITS:0]   o_data
);

    logic [FRAC_BITS:0] w_table [c_rom_depth];

    for (genvar i = 0; i < c_rom_depth; i++) begin : g_rom
        localparam logic [FRAC_BITS:0] c_val = (FRAC_BITS + 1)'(sin_q(i, FRAC_BITS));
        assign w_table[i] = c_val;
    end

    // Registered table read; addresses beyond 90 degrees return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_data <= '0;
        end else if (i_addr < 7'(c_rom_depth)) begin
            o_data <= w_table[i_addr];
        end else begin
            o_data <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trig_bcd_unit.sv
// ============================================================================
//  Module      : trig_bcd_unit
//  Description : Sine/cosine of a whole-degree angle, reported as sign plus
//                DIGITS BCD digits (one integer digit, the rest fraction).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_bcd_unit
    import trig_pkg::*;
#(
    parameter int DIGITS    = c_default_digits,
    parameter int FRAC_BITS = c_default_frac_bits
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8:0]            angle,
    input  logic                  mode,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   digits,
    output logic                  sign,
    output logic                  err
);

    state_t                 r_state;
    state_t                 w_next;
    logic [8:0]             r_angle;
    logic                   r_mode;
    logic                   r_err;
    logic                   r_neg;
    logic [6:0]             r_red;
    logic [FRAC_BITS-1:0]   r_frac;
    logic [DIGITS*4-1:0]    r_bcd;
    logic [3:0]             r_cnt;

    logic [9:0]             w_shift;
    logic [9:0]             w_fold;
    logic [9:0]             w_red_full;
    logic                   w_neg;
    logic [FRAC_BITS:0]     w_rom_data;
    logic [FRAC_BITS+3:0]   w_x10;
    logic [3:0]             w_digit;
    logic [FRAC_BITS-1:0]   w_frac_next;

    sin_quarter_rom #(
        .FRAC_BITS (FRAC_BITS)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_addr (r_red),
        .o_data (w_rom_data)
    );

    assign busy = (r_state != ST_IDLE);

    // Fold the captured angle into the first quadrant; cosine is sine shifted by 90.
    always_comb begin
        w_shift    = {1'b0, r_angle} + (r_mode ? 10'd90 : 10'd0);
        w_fold     = (w_shift >= 10'd360) ? (w_shift - 10'd360) : w_shift;
        w_red_full = w_fold;
        w_neg      = 1'b0;
        if (w_fold <= 10'd90) begin
            w_red_full = w_fold;
        end else if (w_fold <= 10'd180) begin
            w_red_full = 10'd180 - w_fold;
        end else if (w_fold <= 10'd270) begin
            w_red_full = w_fold - 10'd180;
            w_neg      = 1'b1;
        end else begin
            w_red_full = 10'd360 - w_fold;
            w_neg      = 1'b1;
        end
    end

    // One BCD digit per cycle: first the integer bit, then floor(frac*10).
    always_comb begin
        w_x10       = ({4'b0, r_frac} << 3) + ({4'b0, r_frac} << 1);
        w_digit     = w_x10[FRAC_BITS+3:FRAC_BITS];
        w_frac_next = w_x10[FRAC_BITS-1:0];
        if (r_cnt == 4'd0) begin
            w_digit     = {3'b000, w_rom_data[FRAC_BITS]};
            w_frac_next = w_rom_data[FRAC_BITS-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; out-of-range angles bypass the table and conversion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_REDUCE;
            ST_REDUCE:  w_next = r_err ? ST_DONE : ST_LOOKUP;
            ST_LOOKUP:  w_next = ST_CONVERT;
            ST_CONVERT: if (r_cnt == 4'(DIGITS - 1)) w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Datapath and result registers; results only change on the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_angle <= '0;
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
            r_neg   <= 1'b0;
            r_red   <= '0;
            r_frac  <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            done    <= 1'b0;
            digits  <= '0;
            sign    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_angle <= angle;
                        r_mode  <= mode;
                        r_err   <= (angle > 9'd360);
                        r_neg   <= 1'b0;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_REDUCE: begin
                    r_red <= w_red_full[6:0];
                    r_neg <= w_neg & ~r_err;
                end
                ST_CONVERT: begin
                    r_bcd  <= {r_bcd[DIGITS*4-5:0], w_digit};
                    r_frac <= w_frac_next;
                    r_cnt  <= r_cnt + 4'd1;
                end
                ST_DONE: begin
                    digits <= r_bcd;
                    sign   <= r_neg & (|r_bcd);
                    err    <= r_err;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_trig_bcd_unit.sv
// ============================================================================
//  Module      : tb_trig_bcd_unit
//  Description : Directed self-checking bench for trig_bcd_unit, with one
//                4-digit and one 6-digit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_trig_bcd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  angle_a, angle_b;
    logic        mode_a, mode_b, start_a, start_b;
    logic        busy_a, done_a, sign_a, err_a;
    logic        busy_b, done_b, sign_b, err_b;
    logic [15:0] digits_a;
    logic [23:0] digits_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          sel     = 0;

    logic        sel_done, sel_busy, sel_sign, sel_err;
    logic [31:0] sel_digits;

    always #5 clk = ~clk;

    trig_bcd_unit #(.DIGITS(4), .FRAC_BITS(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .angle(angle_a), .mode(mode_a), .start(start_a),
        .busy(busy_a), .done(done_a), .digits(digits_a), .sign(sign_a), .err(err_a)
    );

    trig_bcd_unit #(.DIGITS(6), .FRAC_BITS(16)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .angle(angle_b), .mode(mode_b), .start(start_b),
        .busy(busy_b), .done(done_b), .digits(digits_b), .sign(sign_b), .err(err_b)
    );

    assign sel_done   = (sel == 0) ? done_a : done_b;
    assign sel_busy   = (sel == 0) ? busy_a : busy_b;
    assign sel_sign   = (sel == 0) ? sign_a : sign_b;
    assign sel_err    = (sel == 0) ? err_a  : err_b;
    assign sel_digits = (sel == 0) ? {16'h0, digits_a} : {8'h0, digits_b};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [8:0] a, input logic m);
        if (sel == 0) begin
            start_a = s; angle_a = a; mode_a = m;
        end else begin
            start_b = s; angle_b = a; mode_b = m;
        end
    endtask

    // One request: expected BCD given as hex nibbles, latency in cycles from accept edge.
    task automatic run_req(input int inst, input logic [8:0] a, input logic m,
                           input logic [31:0] exp_d, input logic exp_s, input logic exp_e,
                           input int exp_lat);
        int    lat;
        bit    seen;
        string t;
        sel = inst;
        t   = $sformatf("D%0d a=%0d m=%0d", (inst == 0) ? 4 : 6, a, m);
        @(negedge clk);
        drive(1'b1, a, m);
        @(posedge clk);
        #1;
        drive(1'b0, a, m);
        check_val({t, " busy"}, 32'(sel_busy), 32'd1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (sel_done) seen = 1;
        end
        check_val({t, " done_seen"}, 32'(seen), 32'd1);
        check_val({t, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({t, " digits"}, sel_digits, exp_d);
        check_val({t, " sign"}, 32'(sel_sign), 32'(exp_s));
        check_val({t, " err"}, 32'(sel_err), 32'(exp_e));
        @(posedge clk);
        #1;
        check_val({t, " done_pulse"}, 32'(sel_done), 32'd0);
        check_val({t, " digits_hold"}, sel_digits, exp_d);
    endtask

    initial begin
        int first;
        int second;
        int ndone;

        rst_n = 1'b0;
        start_a = 0; angle_a = 0; mode_a = 0;
        start_b = 0; angle_b = 0; mode_b = 0;
        repeat (2) @(negedge clk);
        check_val("reset busy4",   32'(busy_a),   32'd0);
        check_val("reset done4",   32'(done_a),   32'd0);
        check_val("reset digits4", 32'(digits_a), 32'd0);
        check_val("reset digits6", 32'(digits_b), 32'd0);
        check_val("reset err6",    32'(err_b),    32'd0);
        rst_n = 1'b1;

        // 4-digit instance
        run_req(0,   0, 0, 32'h0000, 0, 0, 7);
        run_req(0,  90, 0, 32'h1000, 0, 0, 7);
        run_req(0,  45, 0, 32'h0707, 0, 0, 7);
        run_req(0,  60, 1, 32'h0500, 0, 0, 7);
        run_req(0, 100, 0, 32'h0984, 0, 0, 7);
        run_req(0, 260, 0, 32'h0984, 1, 0, 7);
        run_req(0, 180, 0, 32'h0000, 0, 0, 7);
        run_req(0, 400, 0, 32'h0000, 0, 1, 2);
        run_req(0, 360, 0, 32'h0000, 0, 0, 7);

        // 6-digit instance
        run_req(1,   0, 0, 32'h000000, 0, 0, 9);
        run_req(1,  90, 0, 32'h100000, 0, 0, 9);
        run_req(1,  45, 0, 32'h070710, 0, 0, 9);
        run_req(1,  60, 1, 32'h050000, 0, 0, 9);
        run_req(1, 100, 0, 32'h098480, 0, 0, 9);
        run_req(1, 260, 0, 32'h098480, 1, 0, 9);
        run_req(1, 180, 0, 32'h000000, 0, 0, 9);

        // start held high: one done every DIGITS+4 cycles
        sel = 0;
        first = -1; second = -1; ndone = 0;
        @(negedge clk);
        drive(1'b1, 9'd45, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                ndone++;
                check_val("held busy_at_done", 32'(busy_a), 32'd0);
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 10) check_val("held busy_mid", 32'(busy_a), 32'd1);
        end
        drive(1'b0, 9'd45, 1'b0);
        check_val("held done_count", 32'(ndone), 32'd2);
        check_val("held first_done", 32'(first), 32'd7);
        check_val("held period", 32'(second - first), 32'd8);
        repeat (12) @(posedge clk);
        #1;
        check_val("held drained", 32'(busy_a), 32'd0);
        check_val("held digits", 32'(digits_a), 32'h0707);

        // reset during CONVERT
        @(negedge clk);
        drive(1'b1, 9'd100, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 9'd100, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("rst busy",   32'(busy_a),   32'd0);
        check_val("rst done",   32'(done_a),   32'd0);
        check_val("rst digits", 32'(digits_a), 32'd0);
        check_val("rst sign",   32'(sign_a),   32'd0);
        check_val("rst err",    32'(err_a),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        check_val("rst no_done", 32'(ndone), 32'd0);
        run_req(0, 90, 0, 32'h1000, 0, 0, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
